seq_detector: RTL and testbench

Parametrised, programmable serial sequence detector. It is the next generation of the team's fixed Moore "1101" recogniser. The block samples a qualified serial bit stream and compares the last `PAT_W` bits against a run-time loadable pattern with a per-bit don't-care mask. It supports overlapping and non-overlapping detection and counts matches in a saturating counter. It sits behind the serial receive front end and feeds status and interrupt logic.

---
 rtl/seq_det_pkg.sv | 20 ++
 rtl/flex_stp_sr.sv | 41 ++++
 rtl/seq_detector.sv | 134 +++++++++++++
 tb/tb_seq_detector.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/seq_det_pkg.sv
// -----------------------------------------------------------------------------
// seq_det_pkg
// Shared types and constant helpers for the programmable sequence detector.
//   state_t    : detector FSM state (FILL while the history is not yet valid,
//                ARMED once PAT_W valid bits are held).
//   fill_width : width needed for a fill counter that counts 0..pat_w.
// -----------------------------------------------------------------------------
package seq_det_pkg;

    typedef enum logic [0:0] {
        FILL  = 1'b0,
        ARMED = 1'b1
    } state_t;

    // The fill counter must be able to hold the value pat_w itself.
    function automatic int fill_width(input int pat_w);
        return $clog2(pat_w + 1);
    endfunction

endpackage

// File: rtl/flex_stp_sr.sv
// -----------------------------------------------------------------------------
// flex_stp_sr
// Flexible serial-to-parallel shift register with synchronous clear.
//   clk          : clock, rising edge
//   n_rst        : asynchronous active-low reset (register cleared to 0)
//   shift_enable : shift one bit in on this edge
//   clear        : synchronous clear, priority over shift_enable
//   serial_in    : bit shifted in
//   parallel_out : register contents
// SHIFT_MSB = 1 shifts toward the MSB (new bit enters at bit 0), so the
// oldest bit sits in the MSB; SHIFT_MSB = 0 shifts toward the LSB.
// -----------------------------------------------------------------------------
module flex_stp_sr #(
    parameter int NUM_BITS  = 4,
    parameter bit SHIFT_MSB = 1'b1
) (
    input  logic                clk,
    input  logic                n_rst,
    input  logic                shift_enable,
    input  logic                clear,
    input  logic                serial_in,
    output logic [NUM_BITS-1:0] parallel_out
);

    // NOTE: sequential state is updated with non-blocking assignments so every
    // flop samples pre-edge values regardless of process evaluation order.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            parallel_out <= '0;
        end else if (clear) begin
            parallel_out <= '0;
        end else if (shift_enable) begin
            if (SHIFT_MSB) begin
                parallel_out <= {parallel_out[NUM_BITS-2:0], serial_in};
            end else begin
                parallel_out <= {serial_in, parallel_out[NUM_BITS-1:1]};
            end
        end
    end

endmodule

// File: rtl/seq_detector.sv
// -----------------------------------------------------------------------------
// seq_detector
// Programmable serial sequence detector with don't-care mask, overlapping or
// non-overlapping detection and a saturating match counter.
//   clk         : clock, rising edge
//   n_rst       : asynchronous active-low reset
//   serial_in   : data bit, sampled only when in_valid = 1
//   in_valid    : qualifies serial_in
//   pat_load    : load pat_in / mask_in / overlap_in, restart the history
//   pat_in      : pattern, MSB is the first bit received
//   mask_in     : 1 = compare bit, 0 = don't care
//   overlap_in  : 1 = overlapping detection, 0 = non-overlapping
//   clr_count   : synchronous clear of match_count (wins over a hit)
//   match       : registered one-cycle pulse per detection
//   match_count : saturating detection count
//   armed       : history holds at least PAT_W valid bits
// -----------------------------------------------------------------------------
module seq_detector
    import seq_det_pkg::*;
#(
    parameter int               PAT_W       = 4,
    parameter int               CNT_W       = 8,
    parameter logic [PAT_W-1:0] RST_PAT     = PAT_W'(4'b1101),
    parameter bit               RST_OVERLAP = 1'b1
) (
    input  logic             clk,
    input  logic             n_rst,
    input  logic             serial_in,
    input  logic             in_valid,
    input  logic             pat_load,
    input  logic [PAT_W-1:0] pat_in,
    input  logic [PAT_W-1:0] mask_in,
    input  logic             overlap_in,
    input  logic             clr_count,
    output logic             match,
    output logic [CNT_W-1:0] match_count,
    output logic             armed
);

    localparam int               FILL_W = fill_width(PAT_W);
    localparam logic [FILL_W-1:0] FULL  = FILL_W'(PAT_W);

    logic [PAT_W-1:0]  hist;
    logic [PAT_W-1:0]  next_hist;
    logic [PAT_W-1:0]  pattern_q;
    logic [PAT_W-1:0]  mask_q;
    logic              overlap_q;
    logic [FILL_W-1:0] fill_q, fill_d, fill_inc;
    state_t            state_q, state_d;
    logic              sample;
    logic              hit;

    // A load discards the bit presented on the same edge.
    assign sample = in_valid & ~pat_load;

    flex_stp_sr #(
        .NUM_BITS  (PAT_W),
        .SHIFT_MSB (1'b1)
    ) u_hist (
        .clk          (clk),
        .n_rst        (n_rst),
        .shift_enable (sample),
        .clear        (pat_load),
        .serial_in    (serial_in),
        .parallel_out (hist)
    );

    // Next-state, fill count and hit evaluation.
    // NOTE: every signal assigned here gets a default first; a path that
    // leaves one unassigned would infer a latch.
    always_comb begin
        next_hist = {hist[PAT_W-2:0], serial_in};
        fill_inc  = (fill_q == FULL) ? FULL : fill_q + FILL_W'(1);
        hit       = sample && (fill_inc == FULL) &&
                    (((next_hist ^ pattern_q) & mask_q) == '0);
        state_d   = state_q;
        fill_d    = fill_q;

        if (pat_load) begin
            fill_d  = '0;
            state_d = FILL;
        end else if (sample) begin
            if (hit && !overlap_q) begin
                // Non-overlapping: the next hit needs PAT_W fresh bits.
                fill_d  = '0;
                state_d = FILL;
            end else begin
                fill_d = fill_inc;
                if (fill_inc == FULL) begin
                    state_d = ARMED;
                end
            end
        end
    end

    // NOTE: all control and data registers take a defined reset value; there
    // is no storage array here that could be left unreset.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q   <= FILL;
            fill_q    <= '0;
            pattern_q <= RST_PAT;
            mask_q    <= '1;
            overlap_q <= RST_OVERLAP;
        end else begin
            state_q <= state_d;
            fill_q  <= fill_d;
            if (pat_load) begin
                pattern_q <= pat_in;
                mask_q    <= mask_in;
                overlap_q <= overlap_in;
            end
        end
    end

    // Registered outputs: match pulse and saturating counter.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            match       <= 1'b0;
            match_count <= '0;
        end else begin
            match <= hit;
            if (clr_count) begin
                match_count <= '0;
            end else if (hit && (match_count != '1)) begin
                match_count <= match_count + CNT_W'(1);
            end
        end
    end

    // state_q is a single flop, so armed is a direct flop output.
    assign armed = (state_q == ARMED);

endmodule

// File: tb/tb_seq_detector.sv
// -----------------------------------------------------------------------------
// tb_seq_detector
// Two detector instances share one stimulus stream: dut_a with default
// parameters and dut_b with a 2-bit counter to exercise saturation. A
// behavioural model keeps the received bits and pushes the expected outputs
// into a scoreboard queue before each edge; they are popped and compared
// just after the edge.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_seq_detector;

    logic       clk = 1'b0;
    logic       n_rst;
    logic       serial_in, in_valid, pat_load, overlap_in, clr_count;
    logic [3:0] pat_in, mask_in;
    logic       match_a, armed_a, match_b, armed_b;
    logic [7:0] count_a;
    logic [1:0] count_b;

    always #5 clk = ~clk;

    seq_detector dut_a (
        .clk (clk), .n_rst (n_rst), .serial_in (serial_in), .in_valid (in_valid),
        .pat_load (pat_load), .pat_in (pat_in), .mask_in (mask_in),
        .overlap_in (overlap_in), .clr_count (clr_count),
        .match (match_a), .match_count (count_a), .armed (armed_a)
    );

    seq_detector #(.CNT_W(2)) dut_b (
        .clk (clk), .n_rst (n_rst), .serial_in (serial_in), .in_valid (in_valid),
        .pat_load (pat_load), .pat_in (pat_in), .mask_in (mask_in),
        .overlap_in (overlap_in), .clr_count (clr_count),
        .match (match_b), .match_count (count_b), .armed (armed_b)
    );

    typedef struct {
        logic       m;
        logic [7:0] c8;
        logic [1:0] c2;
        logic       a;
    } exp_t;

    exp_t exp_q[$];
    int   n_vec = 0;
    int   n_err = 0;

    // Model state: received bits (oldest first), bits since restart, config.
    bit   m_bits[$];
    int   m_fill;
    bit [3:0] m_pat, m_mask;
    bit   m_ovl;
    int   m_c8, m_c2;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_vec++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, want, $time);
        end
    endtask

    task automatic model_reset();
        m_bits.delete();
        m_fill = 0;
        m_pat  = 4'b1101;
        m_mask = 4'b1111;
        m_ovl  = 1'b1;
        m_c8   = 0;
        m_c2   = 0;
    endtask

    // Does the last four received bits match the pattern under the mask?
    function automatic bit window_hits();
        int n = m_bits.size();
        for (int k = 0; k < 4; k++) begin
            // k = 0 is the oldest of the last four bits, pattern MSB.
            if (m_mask[3-k] && (m_bits[n-4+k] != m_pat[3-k])) return 1'b0;
        end
        return 1'b1;
    endfunction

    // Drive one cycle (called just after a falling edge), predict, compare.
    task automatic step(input bit v, input bit b, input bit ld, input bit clr);
        exp_t e;
        bit   hit = 1'b0;
        in_valid  = v;
        serial_in = b;
        pat_load  = ld;
        clr_count = clr;
        if (ld) begin
            m_pat  = pat_in;
            m_mask = mask_in;
            m_ovl  = overlap_in;
            m_fill = 0;
            m_bits.delete();
        end else if (v) begin
            m_bits.push_back(b);
            if (m_fill < 4) m_fill++;
            hit = (m_fill == 4) && window_hits();
            if (hit && !m_ovl) m_fill = 0;
        end
        if (clr) begin
            m_c8 = 0;
            m_c2 = 0;
        end else if (hit) begin
            if (m_c8 < 255) m_c8++;
            if (m_c2 < 3)   m_c2++;
        end
        e.m  = hit;
        e.c8 = 8'(m_c8);
        e.c2 = 2'(m_c2);
        e.a  = (m_fill == 4);
        exp_q.push_back(e);

        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        check("match_a", 32'(match_a), 32'(e.m));
        check("armed_a", 32'(armed_a), 32'(e.a));
        check("count_a", 32'(count_a), 32'(e.c8));
        check("match_b", 32'(match_b), 32'(e.m));
        check("count_b", 32'(count_b), 32'(e.c2));
        @(negedge clk);
    endtask

    task automatic send(input string s);
        for (int i = 0; i < s.len(); i++) step(1'b1, s[i] == "1", 1'b0, 1'b0);
    endtask

    // Load a new configuration; the data bit offered alongside is discarded.
    task automatic load(input logic [3:0] p, input logic [3:0] m, input bit ovl, input bit clr);
        pat_in     = p;
        mask_in    = m;
        overlap_in = ovl;
        step(1'b1, 1'b1, 1'b1, clr);
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_match"}, 32'(match_a), 32'd0);
        check({tag, "_count"}, 32'(count_a), 32'd0);
        check({tag, "_armed"}, 32'(armed_a), 32'd0);
        check({tag, "_cntb"},  32'(count_b), 32'd0);
    endtask

    initial begin
        n_rst = 1'b0;
        {serial_in, in_valid, pat_load, overlap_in, clr_count} = '0;
        pat_in  = 4'b0000;
        mask_in = 4'b0000;
        model_reset();
        #1;
        check_reset_values("reset");
        @(negedge clk);
        @(negedge clk);
        n_rst = 1'b1;

        // Reset configuration: 1101, overlapping.
        send("1101101");
        check("default_total", 32'(count_a), 32'd2);

        // Same stream, non-overlapping.
        load(4'b1101, 4'b1111, 1'b0, 1'b1);
        send("1101101");
        check("nonovl_total", 32'(count_a), 32'd1);

        // Masked pattern 1xx1, overlapping.
        load(4'b1001, 4'b1001, 1'b1, 1'b1);
        send("11111011");

        // Counter saturation on dut_b, then clear coincident with a hit.
        load(4'b1111, 4'b1111, 1'b1, 1'b1);
        send("11111111");
        check("sat_cnt_b", 32'(count_b), 32'd3);
        step(1'b1, 1'b1, 1'b0, 1'b1);
        check("clr_hit_match", 32'(match_a), 32'd1);

        // All-zero mask: hit on every valid bit once armed.
        load(4'b0000, 4'b0000, 1'b1, 1'b1);
        send("010011");

        // Valid gap: bits offered with in_valid low must be ignored.
        load(4'b1101, 4'b1111, 1'b1, 1'b1);
        send("110");
        for (int i = 0; i < 5; i++) step(1'b0, i[0], 1'b0, 1'b0);
        send("1");

        // Load during 1101 with in_valid high: the final bit is discarded.
        load(4'b1101, 4'b1111, 1'b1, 1'b0);
        send("110");
        load(4'b1101, 4'b1111, 1'b1, 1'b0);
        check("load_armed", 32'(armed_a), 32'd0);
        send("1");

        // Asynchronous reset mid-stream.
        send("110");
        #2;
        n_rst = 1'b0;
        #1;
        check_reset_values("async");
        model_reset();
        @(posedge clk);
        @(negedge clk);
        n_rst = 1'b1;
        send("1");
        check_reset_values("post_rst");

        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL scoreboard: %0d entries left, expected 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
